// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the paddle/ball blocks of the pong game.
//   COORD_W  : width of every screen coordinate (paddle_move x/y, ball x/y)
//   SCREEN_H : visible screen height in pixels
//   state_e  : round-flow state encoding, also exported on state_o
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int COORD_W  = 13;
    localparam int SCREEN_H = 1920;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_SERVE  = 2'd1,
        S_PLAY   = 2'd2,
        S_FREEZE = 2'd3
    } state_e;

endpackage

// File: rtl/paddle_ctrl_if.sv
// -----------------------------------------------------------------------------
// paddle_ctrl_if
// Link between paddle_ctrl and its paddle_move instance.
//   move_up    : one-cycle step request, y decreases
//   move_down  : one-cycle step request, y increases
//   paddle_rst : active-high re-initialisation of paddle_move
//   paddle_y   : current paddle y position reported back by paddle_move
// Modports: master = paddle_ctrl side, slave = paddle_move side.
// -----------------------------------------------------------------------------
interface paddle_ctrl_if;
    import pong_pkg::*;

    logic               move_up;
    logic               move_down;
    logic               paddle_rst;
    logic [COORD_W-1:0] paddle_y;

    modport master (
        output move_up,
        output move_down,
        output paddle_rst,
        input  paddle_y
    );

    modport slave (
        input  move_up,
        input  move_down,
        input  paddle_rst,
        output paddle_y
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw asynchronous button into the clk domain and only lets the
// debounced level follow once the synchronised level has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw button pin
//   btn_db     : debounced level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse the 2-FF synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            if (sync_q[1] != db_q) begin
                // Level has been different long enough: accept it.
                if (cnt_q == CNT_LAST) begin
                    db_q  <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl
// Per-paddle sequencer: decides when and which way paddle_move steps (from
// debounced buttons or an AI ball tracker, at most once per frame) and runs the
// round flow S_RESET -> S_SERVE -> S_PLAY -> S_FREEZE -> S_RESET.
//   clk, rst_n        : clock, asynchronous active-low reset
//   frame_tick        : one-cycle pulse per video frame
//   btn_up, btn_down  : raw asynchronous player buttons
//   ai_enable         : 1 = AI tracker drives the paddle, 0 = buttons
//   ball_y            : ball centre y
//   round_start       : restart the round (highest priority)
//   serve_go          : ball served (S_SERVE -> S_PLAY)
//   point_scored      : point over (S_PLAY -> S_FREEZE)
//   pm                : move_up/move_down/paddle_rst out, paddle_y in
//   state_o           : current round state encoding
// -----------------------------------------------------------------------------
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned AI_DEADZONE     = 24,
    parameter int unsigned FREEZE_FRAMES   = 60,
    parameter int unsigned RST_CYCLES      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               ai_enable,
    input  logic [COORD_W-1:0] ball_y,
    input  logic               round_start,
    input  logic               serve_go,
    input  logic               point_scored,
    paddle_ctrl_if.master      pm,
    output logic [1:0]         state_o
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned FRZ_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;
    localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [FRZ_W-1:0]   FRZ_LAST = FRZ_W'(FREEZE_FRAMES - 1);
    // One extra bit so ball_y + deadzone can never wrap.
    localparam logic [COORD_W:0]   DZ       = (COORD_W + 1)'(AI_DEADZONE);

    logic db_up;
    logic db_down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_up),
        .btn_db  (db_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_down),
        .btn_db  (db_down)
    );

    // Direction wanted this frame; only consumed when frame_tick is high, so
    // ai_enable effectively takes effect at the next tick.
    logic [COORD_W:0] ball_ext;
    logic [COORD_W:0] pad_ext;
    logic             want_up;
    logic             want_down;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        want_up   = 1'b0;
        want_down = 1'b0;
        ball_ext  = {1'b0, ball_y};
        pad_ext   = {1'b0, pm.paddle_y};
        if (ai_enable) begin
            want_up   = (ball_ext + DZ) < pad_ext;
            want_down = ball_ext > (pad_ext + DZ);
        end else begin
            // Both buttons pressed cancel each other out.
            want_up   = db_up & ~db_down;
            want_down = db_down & ~db_up;
        end
    end

    state_e           state_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic [FRZ_W-1:0] frz_cnt_q;
    logic             move_up_q;
    logic             move_down_q;
    logic             paddle_rst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            rst_cnt_q    <= '0;
            frz_cnt_q    <= '0;
            move_up_q    <= 1'b0;
            move_down_q  <= 1'b0;
            paddle_rst_q <= 1'b1;
        end else begin
            // Moves are single-cycle pulses: cleared unless set below.
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;

            if (round_start) begin
                state_q      <= S_RESET;
                rst_cnt_q    <= '0;
                paddle_rst_q <= 1'b1;
            end else begin
                case (state_q)
                    S_RESET: begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_q      <= S_SERVE;
                            rst_cnt_q    <= '0;
                            paddle_rst_q <= 1'b0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 1'b1;
                        end
                    end
                    S_SERVE: begin
                        if (serve_go) state_q <= S_PLAY;
                    end
                    S_PLAY: begin
                        // A point suppresses a move in the same cycle.
                        if (point_scored) begin
                            state_q   <= S_FREEZE;
                            frz_cnt_q <= '0;
                        end else if (frame_tick) begin
                            move_up_q   <= want_up;
                            move_down_q <= want_down;
                        end
                    end
                    S_FREEZE: begin
                        if (frame_tick) begin
                            if (frz_cnt_q == FRZ_LAST) begin
                                state_q      <= S_RESET;
                                rst_cnt_q    <= '0;
                                frz_cnt_q    <= '0;
                                paddle_rst_q <= 1'b1;
                            end else begin
                                frz_cnt_q <= frz_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_RESET;
                endcase
            end
        end
    end

    assign pm.move_up    = move_up_q;
    assign pm.move_down  = move_down_q;
    assign pm.paddle_rst = paddle_rst_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paddle_ctrl
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a behavioural model of paddle_ctrl.
// -----------------------------------------------------------------------------
module tb_paddle_ctrl;
    import pong_pkg::*;

    localparam int DB = 4;
    localparam int DZ = 24;
    localparam int FF = 3;
    localparam int RC = 2;

    logic               clk          = 1'b0;
    logic               rst_n        = 1'b0;
    logic               frame_tick   = 1'b0;
    logic               btn_up       = 1'b0;
    logic               btn_down     = 1'b0;
    logic               ai_enable    = 1'b0;
    logic [COORD_W-1:0] ball_y       = '0;
    logic               round_start  = 1'b0;
    logic               serve_go     = 1'b0;
    logic               point_scored = 1'b0;
    logic [1:0]         state_o;

    paddle_ctrl_if pif ();

    paddle_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .AI_DEADZONE     (DZ),
        .FREEZE_FRAMES   (FF),
        .RST_CYCLES      (RC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .ai_enable    (ai_enable),
        .ball_y       (ball_y),
        .round_start  (round_start),
        .serve_go     (serve_go),
        .point_scored (point_scored),
        .pm           (pif),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 reset, 1 serve, 2 play, 3 freeze (the state_o values).
    int m_phase, m_rst_elapsed, m_frames, m_up, m_down, m_prst;
    int m_pipe [2][2];   // [button][stage] raw samples on the way in
    int m_db   [2];      // debounced level per button
    int m_run  [2];      // consecutive cycles the synced level disagreed
    int raw    [2];
    int bv, pv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_rst_elapsed = 0; m_frames = 0;
            m_up = 0; m_down = 0; m_prst = 1;
            for (int b = 0; b < 2; b++) begin
                m_pipe[b][0] = 0; m_pipe[b][1] = 0; m_db[b] = 0; m_run[b] = 0;
            end
        end else begin
            m_up = 0;
            m_down = 0;
            if (round_start) begin
                m_phase = 0; m_rst_elapsed = 0; m_prst = 1;
            end else if (m_phase == 0) begin
                m_rst_elapsed++;
                if (m_rst_elapsed == RC) begin m_phase = 1; m_prst = 0; end
            end else if (m_phase == 1) begin
                if (serve_go) m_phase = 2;
            end else if (m_phase == 2) begin
                if (point_scored) begin
                    m_phase = 3; m_frames = 0;
                end else if (frame_tick) begin
                    if (ai_enable) begin
                        bv = int'(ball_y);
                        pv = int'(pif.paddle_y);
                        m_up   = (bv + DZ < pv) ? 1 : 0;
                        m_down = (bv > pv + DZ) ? 1 : 0;
                    end else begin
                        m_up   = (m_db[0] == 1 && m_db[1] == 0) ? 1 : 0;
                        m_down = (m_db[1] == 1 && m_db[0] == 0) ? 1 : 0;
                    end
                end
            end else begin
                if (frame_tick) begin
                    m_frames++;
                    if (m_frames == FF) begin
                        m_phase = 0; m_rst_elapsed = 0; m_prst = 1;
                    end
                end
            end
            // Buttons: accept a new level after DB cycles of disagreement.
            raw[0] = int'(btn_up);
            raw[1] = int'(btn_down);
            for (int b = 0; b < 2; b++) begin
                if (m_pipe[b][1] != m_db[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == DB) begin m_db[b] = m_pipe[b][1]; m_run[b] = 0; end
                m_pipe[b][1] = m_pipe[b][0];
                m_pipe[b][0] = raw[b];
            end
        end
    end

    // Single compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("m_move_up",    int'(pif.move_up),    m_up);
        check("m_move_down",  int'(pif.move_down),  m_down);
        check("m_paddle_rst", int'(pif.paddle_rst), m_prst);
        check("m_state",      int'(state_o),        m_phase);
        check("m_exclusive",  int'(pif.move_up & pif.move_down), 0);
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge: tick for one cycle, check the pulse, then
    // check it lasted exactly one cycle.
    task automatic tick_check(input string name, input int eu, input int ed);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check({name, "_up"},   int'(pif.move_up),   eu);
        check({name, "_down"}, int'(pif.move_down), ed);
        @(negedge clk);
        check({name, "_single"}, int'(pif.move_up | pif.move_down), 0);
    endtask

    task automatic lit_state(input string name, input int st, input int prst);
        check({name, "_state"}, int'(state_o), st);
        check({name, "_prst"},  int'(pif.paddle_rst), prst);
    endtask

    initial begin
        int p, b;
        pif.paddle_y = '0;

        // Reset and round start.
        cyc(3);
        lit_state("in_reset", 0, 1);
        check("in_reset_moves", int'(pif.move_up | pif.move_down), 0);
        rst_n = 1'b1;
        cyc(1);
        lit_state("rel_c1", 0, 1);
        cyc(1);
        lit_state("rel_c2", 1, 0);

        // Locked in serve even with a debounced button.
        btn_up = 1'b1;
        cyc(10);
        tick_check("serve_lock", 0, 0);
        serve_go = 1'b1; cyc(1); serve_go = 1'b0;
        lit_state("to_play", 2, 0);

        // Human play.
        for (int i = 0; i < 3; i++) begin
            tick_check("human_up", 1, 0);
            cyc(3);
        end
        btn_down = 1'b1;
        cyc(10);
        tick_check("both_btn", 0, 0);
        btn_up = 1'b0; btn_down = 1'b0;
        cyc(10);
        btn_down = 1'b1; cyc(2); btn_down = 1'b0;
        cyc(8);
        tick_check("glitch", 0, 0);

        // AI deadzone.
        ai_enable = 1'b1;
        pif.paddle_y = 13'd500;
        ball_y = 13'd476;  cyc(1); tick_check("ai_476", 0, 0);
        ball_y = 13'd475;  cyc(1); tick_check("ai_475", 1, 0);
        ball_y = 13'd525;  cyc(1); tick_check("ai_525", 0, 1);
        ball_y = 13'd524;  cyc(1); tick_check("ai_524", 0, 0);
        pif.paddle_y = 13'd8180;
        ball_y = 13'd8191; cyc(1); tick_check("ai_top", 0, 0);
        pif.paddle_y = 13'd8191;
        ball_y = 13'd0;    cyc(1); tick_check("ai_far", 1, 0);

        // ai_enable only matters at the tick.
        pif.paddle_y = 13'd500;
        ball_y = 13'd1000;
        btn_up = 1'b1;
        cyc(10);
        tick_check("src_ai", 0, 1);
        ai_enable = 1'b0; cyc(3);
        tick_check("src_btn", 1, 0);
        ai_enable = 1'b1; cyc(3); ai_enable = 1'b0; cyc(2);
        tick_check("src_btn_again", 1, 0);
        ai_enable = 1'b1; cyc(2);
        tick_check("src_ai_again", 0, 1);

        // Freeze: point beats the tick.
        frame_tick = 1'b1; point_scored = 1'b1;
        cyc(1);
        frame_tick = 1'b0; point_scored = 1'b0;
        check("point_no_move", int'(pif.move_up | pif.move_down), 0);
        lit_state("frz_enter", 3, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(4); frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
            lit_state("frz_hold", 3, 0);
        end
        cyc(4); frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        lit_state("frz_exit_c1", 0, 1);
        cyc(1);
        lit_state("frz_exit_c2", 0, 1);
        cyc(1);
        lit_state("frz_serve", 1, 0);

        // round_start beats serve_go; point outside play ignored.
        round_start = 1'b1; serve_go = 1'b1; cyc(1);
        round_start = 1'b0; serve_go = 1'b0;
        lit_state("rs_over_serve", 0, 1);
        cyc(2);
        lit_state("rs_back_serve", 1, 0);
        point_scored = 1'b1; cyc(1); point_scored = 1'b0;
        lit_state("point_in_serve", 1, 0);
        serve_go = 1'b1; cyc(1); serve_go = 1'b0;
        lit_state("play_again", 2, 0);

        // Asynchronous reset in the middle of a move pulse.
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("pre_rst_pulse", int'(pif.move_down), 1);
        rst_n = 1'b0;
        #1;
        check("async_up",   int'(pif.move_up),    0);
        check("async_down", int'(pif.move_down),  0);
        check("async_prst", int'(pif.paddle_rst), 1);
        check("async_state", int'(state_o),       0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        lit_state("after_async", 1, 0);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            frame_tick   = ($urandom_range(0, 7) == 0);
            round_start  = ($urandom_range(0, 299) == 0);
            serve_go     = ($urandom_range(0, 19) == 0);
            point_scored = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 11) == 0) btn_up   = ~btn_up;
            if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 39) == 0) ai_enable = ~ai_enable;
            if ($urandom_range(0, 3) == 0) begin
                p = int'($urandom_range(0, 8191));
                if ($urandom_range(0, 3) == 0) begin
                    b = int'($urandom_range(0, 8191));
                end else begin
                    b = p + int'($urandom_range(0, 80)) - 40;
                    if (b < 0) b = 0;
                    if (b > 8191) b = 8191;
                end
                pif.paddle_y = p[COORD_W-1:0];
                ball_y       = b[COORD_W-1:0];
            end
            cyc(1);
        end
        frame_tick = 1'b0; round_start = 1'b0; serve_go = 1'b0; point_scored = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
